// File: rtl/layer_sched.sv
// layer_sched: walks a frame across LAYERS layer controllers in index order.
// Each enabled layer gets a one-cycle start pulse, must acknowledge by raising
// busy within ACK_TMO cycles, and is then waited on until it finishes.
// After the last layer a programmable reset gap runs before frame_done.
// A start request arriving mid-frame is remembered (one deep) and replayed
// immediately after the current frame.
module layer_sched #(
  parameter int LAYERS  = 8,
  parameter int ACK_TMO = 15
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [LAYERS-1:0]           layer_en_i,
  input  logic [LAYERS-1:0]           layer_busy_i,
  input  logic [15:0]                 gap_cnt_i,
  output logic [LAYERS-1:0]           layer_start_o,
  output logic [$clog2(LAYERS)-1:0]   layer_sel_o,
  output logic                        busy_o,
  output logic                        frame_done_o,
  output logic                        ack_err_o
);

  localparam int SW    = $clog2(LAYERS);
  localparam int ACK_W = $clog2(ACK_TMO + 1);
  localparam logic [SW-1:0]    LAST_SEL = SW'(LAYERS - 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TMO - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EVAL  = 3'd1,
    ST_START = 3'd2,
    ST_ACK   = 3'd3,
    ST_RUN   = 3'd4,
    ST_GAP   = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [SW-1:0]     r_sel;
  logic [SW-1:0]     w_sel_next;
  logic              r_pending;
  logic              w_pending_next;
  logic [ACK_W-1:0]  r_ack_cnt;
  logic [ACK_W-1:0]  w_ack_cnt_next;
  logic [15:0]       r_gap_cnt;
  logic [15:0]       w_gap_cnt_next;
  logic              r_ack_err;
  logic              w_ack_err_next;
  logic              w_advance;
  logic [LAYERS-1:0] w_start_next;
  logic [LAYERS-1:0] r_layer_start;
  logic              r_busy;
  logic              r_frame_done;

  // Next-state, counter and flag logic for the sequencer.
  always_comb begin
    w_state_next   = r_state;
    w_sel_next     = r_sel;
    w_pending_next = r_pending;
    w_ack_cnt_next = r_ack_cnt;
    w_gap_cnt_next = r_gap_cnt;
    w_ack_err_next = r_ack_err;
    w_advance      = 1'b0;

    // A start seen mid-frame is queued; DONE consumes start_i directly.
    if (start_i && (r_state != ST_IDLE) && (r_state != ST_DONE)) begin
      w_pending_next = 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_sel_next   = '0;
          w_state_next = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (layer_en_i[r_sel]) begin
          w_state_next = ST_START;
        end else begin
          w_advance = 1'b1;
        end
      end
      ST_START: begin
        w_ack_cnt_next = '0;
        w_state_next   = ST_ACK;
      end
      ST_ACK: begin
        if (layer_busy_i[r_sel]) begin
          w_state_next = ST_RUN;
        end else if (r_ack_cnt == ACK_LAST) begin
          // This cycle is the ACK_TMO-th without an acknowledge: give up on it.
          w_ack_err_next = 1'b1;
          w_advance      = 1'b1;
        end else begin
          w_ack_cnt_next = r_ack_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (!layer_busy_i[r_sel]) begin
          w_advance = 1'b1;
        end
      end
      ST_GAP: begin
        // Exit on 0 or 1 so a programmed gap of 0 still costs one cycle.
        if (r_gap_cnt <= 16'd1) begin
          w_state_next = ST_DONE;
        end else begin
          w_gap_cnt_next = r_gap_cnt - 16'd1;
        end
      end
      ST_DONE: begin
        if (r_pending || start_i) begin
          w_pending_next = 1'b0;
          w_sel_next     = '0;
          w_state_next   = ST_EVAL;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (w_advance) begin
      if (r_sel == LAST_SEL) begin
        w_gap_cnt_next = gap_cnt_i;
        w_state_next   = ST_GAP;
      end else begin
        w_sel_next   = r_sel + 1'b1;
        w_state_next = ST_EVAL;
      end
    end
  end

  // One-hot start decode from the next state so the pulse lines up with START.
  genvar gi;
  generate
    for (gi = 0; gi < LAYERS; gi++) begin : g_start
      assign w_start_next[gi] = (w_state_next == ST_START) && (w_sel_next == SW'(gi));
    end
  endgenerate

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sel         <= '0;
      r_pending     <= 1'b0;
      r_ack_cnt     <= '0;
      r_gap_cnt     <= '0;
      r_ack_err     <= 1'b0;
      r_layer_start <= '0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_sel         <= w_sel_next;
      r_pending     <= w_pending_next;
      r_ack_cnt     <= w_ack_cnt_next;
      r_gap_cnt     <= w_gap_cnt_next;
      r_ack_err     <= w_ack_err_next;
      r_layer_start <= w_start_next;
      r_busy        <= (w_state_next != ST_IDLE);
      r_frame_done  <= (w_state_next == ST_DONE);
    end
  end

  assign layer_start_o = r_layer_start;
  assign layer_sel_o   = r_sel;
  assign busy_o        = r_busy;
  assign frame_done_o  = r_frame_done;
  assign ack_err_o     = r_ack_err;

endmodule

// File: tb/tb_layer_sched.sv
// Scoreboard bench for layer_sched: stimulus pushes the expected event
// sequence (layer start codes, 100 = frame done); a negedge monitor pops
// and compares every event the DUT presents.
module tb_layer_sched;

  localparam int L = 8;
  localparam int DONE_CODE = 100;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [L-1:0] layer_en_i;
  logic [L-1:0] layer_busy_i;
  logic [15:0]  gap_cnt_i;
  logic [L-1:0] layer_start_o;
  logic [2:0]   layer_sel_o;
  logic         busy_o;
  logic         frame_done_o;
  logic         ack_err_o;

  layer_sched #(.LAYERS(L), .ACK_TMO(15)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .layer_en_i   (layer_en_i),
    .layer_busy_i (layer_busy_i),
    .gap_cnt_i    (gap_cnt_i),
    .layer_start_o(layer_start_o),
    .layer_sel_o  (layer_sel_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .ack_err_o    (ack_err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Layer models: busy for 20 cycles, starting 2 cycles after the pulse.
  int           lcnt [L];
  logic [L-1:0] mute;
  always @(posedge clk_i) begin
    for (int i = 0; i < L; i++) begin
      if (layer_start_o[i] && !mute[i]) lcnt[i] <= 22;
      else if (lcnt[i] > 0)             lcnt[i] <= lcnt[i] - 1;
    end
  end
  genvar gi;
  generate
    for (gi = 0; gi < L; gi++) begin : g_busy
      assign layer_busy_i[gi] = (lcnt[gi] > 0) && (lcnt[gi] <= 20);
    end
  endgenerate

  int   expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_seen = 0;
  int   done_cyc = -1;
  int   err_cyc = -1;
  int   pulse_cyc [L];
  logic prev_err = 1'b0;
  int   start_cyc = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_pop(input int got);
    int e;
    n_cmp++;
    if (expq.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got code %0d, expected none (cycle %0d)", got, cyc);
    end else begin
      e = expq.pop_front();
      if (e != got) begin
        n_bad++;
        $display("FAIL event_order: got code %0d, expected %0d (cycle %0d)", got, e, cyc);
      end
    end
  endtask

  // Monitor: compare each start pulse / frame_done against the scoreboard.
  always @(negedge clk_i) begin : mon
    int code;
    code = -1;
    if (layer_start_o != '0) begin
      for (int i = 0; i < L; i++) if (layer_start_o[i]) code = i;
      chk("start_onehot", $countones(layer_start_o), 1);
      chk("sel_at_start", int'(layer_sel_o), code);
      pulse_cyc[code] = cyc;
      $display("event: start layer %0d at cycle %0d", code, cyc);
      check_pop(code);
    end
    if (frame_done_o) begin
      done_seen++;
      done_cyc = cyc;
      $display("event: frame_done at cycle %0d", cyc);
      check_pop(DONE_CODE);
    end
    if (ack_err_o && !prev_err) err_cyc = cyc;
    prev_err = ack_err_o;
  end

  task automatic push_frame(input logic [L-1:0] en);
    for (int i = 0; i < L; i++) if (en[i]) expq.push_back(i);
    expq.push_back(DONE_CODE);
  endtask

  task automatic pulse_start();
    @(negedge clk_i);
    start_i = 1'b1;
    start_cyc = cyc;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (done_seen < target && k < budget) begin
      @(negedge clk_i);
      k++;
    end
    chk({name, "_done_reached"}, int'(done_seen >= target), 1);
    repeat (2) @(negedge clk_i);
    chk({name, "_queue_empty"}, expq.size(), 0);
  endtask

  initial begin : stim
    int   base;
    int   k;
    logic busy_low;
    rst_i = 1'b1;
    start_i = 1'b0;
    layer_en_i = '1;
    gap_cnt_i = 16'd100;
    mute = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_start", int'(layer_start_o), 0);
    chk("rst_sel", int'(layer_sel_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(frame_done_o), 0);
    chk("rst_err", int'(ack_err_o), 0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // All layers enabled, gap 100.
    $display("test: all enabled, gap 100");
    push_frame(8'hFF);
    pulse_start();
    wait_done(1, 3000, "all_en");
    chk("first_pulse_latency", pulse_cyc[0] - start_cyc, 2);
    chk("busy_after_frame", int'(busy_o), 0);

    // Sparse mask.
    $display("test: mask 1010_0101");
    layer_en_i = 8'b1010_0101;
    gap_cnt_i = 16'd4;
    push_frame(8'b1010_0101);
    pulse_start();
    wait_done(2, 3000, "mask_a5");

    // All disabled, gap 0: IDLE, 8 EVAL, 1 GAP, DONE.
    $display("test: all disabled, gap 0");
    layer_en_i = '0;
    gap_cnt_i = 16'd0;
    push_frame(8'h00);
    pulse_start();
    wait_done(3, 200, "all_dis");
    chk("gap0_done_latency", done_cyc - start_cyc, 10);
    chk("err_still_clear", int'(ack_err_o), 0);

    // Layer 3 never acknowledges.
    $display("test: layer 3 ack timeout");
    layer_en_i = '1;
    gap_cnt_i = 16'd5;
    mute = 8'b0000_1000;
    push_frame(8'hFF);
    pulse_start();
    wait_done(4, 3000, "ack_tmo");
    chk("ack_err_set", int'(ack_err_o), 1);
    chk("ack_err_timing", err_cyc - pulse_cyc[3], 16);
    chk("layer4_after_tmo", pulse_cyc[4] - pulse_cyc[3], 17);
    mute = '0;

    // Three mid-frame starts -> exactly one extra frame.
    $display("test: pending start");
    gap_cnt_i = 16'd10;
    base = done_seen;
    push_frame(8'hFF);
    push_frame(8'hFF);
    pulse_start();
    repeat (30) @(negedge clk_i);
    pulse_start();
    pulse_start();
    pulse_start();
    busy_low = 1'b0;
    k = 0;
    while (done_seen < base + 2 && k < 6000) begin
      @(negedge clk_i);
      if (!busy_o && done_seen < base + 2) busy_low = 1'b1;
      k++;
    end
    chk("pending_two_frames", int'(done_seen >= base + 2), 1);
    chk("busy_held_between", int'(busy_low), 0);
    repeat (60) @(negedge clk_i);
    chk("pending_no_third", done_seen - base, 2);
    chk("pending_queue_empty", expq.size(), 0);
    chk("ack_err_sticky", int'(ack_err_o), 1);

    // Reset during layer 4 RUN.
    $display("test: reset mid-frame");
    for (int i = 0; i < 5; i++) expq.push_back(i);
    pulse_start();
    k = 0;
    while (!(layer_sel_o == 3'd4 && layer_busy_i[4]) && k < 2000) begin
      @(negedge clk_i);
      k++;
    end
    chk("reached_layer4_run", int'(k < 2000), 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("midrst_start", int'(layer_start_o), 0);
    chk("midrst_sel", int'(layer_sel_o), 0);
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_err", int'(ack_err_o), 0);
    rst_i = 1'b0;
    repeat (60) @(negedge clk_i);
    chk("midrst_no_pulses", expq.size(), 0);
    base = done_seen;
    push_frame(8'hFF);
    pulse_start();
    wait_done(base + 1, 3000, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/layer_sched.md
LAYER_SCHED -- requirements
Module: layer_sched

Interface
REQ-001 SHALL have parameter LAYERS, default 8: number of layer_code instances sequenced (2..16).
REQ-002 SHALL have parameter ACK_TMO, default 15: max cycles to wait for a started layer to raise busy.
REQ-003 SHALL have port clk_i, input, 1: single clock; all logic rising-edge.
REQ-004 SHALL have port rst_i, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start_i, input, 1: one-cycle pulse; frame data written to all layer RAMs.
REQ-006 SHALL have port layer_en_i, input, LAYERS: per-layer enable mask, sampled when each layer slot is evaluated.
REQ-007 SHALL have port layer_busy_i, input, LAYERS: per-layer "shifting out" status from each layer's ws281x_ctrl.
REQ-008 SHALL have port gap_cnt_i, input, 16: reset-gap length in clk_i cycles after the last layer.
REQ-009 SHALL have port layer_start_o, output, LAYERS: one-hot, one-cycle pulse; drives the selected layer's wr_done_i.
REQ-010 SHALL have port layer_sel_o, output, clog2(LAYERS): index of the current layer.
REQ-011 SHALL have port busy_o, output, 1: high from frame acceptance until frame_done_o.
REQ-012 SHALL have port frame_done_o, output, 1: one-cycle pulse at the end of a frame.
REQ-013 SHALL have port ack_err_o, output, 1: sticky; set on any layer acknowledge timeout.

Function
REQ-014 SHALL implement the FSM states IDLE, EVAL, START, ACK, RUN, GAP, DONE.
REQ-015 IDLE: on start_i=1, SHALL clear sel to 0, set busy_o, and go to EVAL.
REQ-016 EVAL: if layer_en_i[sel]=1, SHALL go to START; otherwise SHALL advance (see REQ-020) without pulsing.
REQ-017 START: SHALL assert layer_start_o[sel]=1 for exactly one cycle, clear the ack counter, and go to ACK; with an enabled layer 0, the pulse appears 2 cycles after the start_i cycle.
REQ-018 ACK: if layer_busy_i[sel]=1, SHALL go to RUN; otherwise the counter SHALL increment, and when it reaches ACK_TMO the block SHALL set ack_err_o and advance.
REQ-019 RUN: SHALL wait until layer_busy_i[sel]=0, then advance.
REQ-020 Advance rule: if sel=LAYERS-1, SHALL go to GAP with the gap counter loaded from gap_cnt_i; else SHALL increment sel (no wrap) and go to EVAL.
REQ-021 GAP: SHALL decrement the counter each cycle and exit to DONE when it reaches 0 or 1; gap_cnt_i=0 or 1 SHALL give exactly 1 GAP cycle.
REQ-022 DONE: SHALL pulse frame_done_o for one cycle; if pending=1, SHALL clear pending, set sel=0, and go to EVAL with busy_o kept high; else SHALL clear busy_o and go to IDLE.
REQ-023 start_i while busy_o=1 SHALL set a one-deep pending flag; further pulses SHALL be absorbed, and the current frame SHALL NOT be disturbed.
REQ-024 start_i in the same cycle as DONE SHALL be treated as pending, so a new frame starts immediately.
REQ-025 layer_start_o SHALL never have more than one bit set.
REQ-026 All layers disabled SHALL pass through each EVAL (one cycle per layer), then GAP, then DONE, with no start pulses.
REQ-027 Busy bits of layers other than sel SHALL be ignored.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 rst_i=1 SHALL force IDLE, sel=0, pending=0, counters=0, layer_start_o=0, busy_o=0, frame_done_o=0, ack_err_o=0, taking effect on the next clock edge.
REQ-030 rst_i asserted mid-frame SHALL abort the sequence with no further start pulses; a layer still shifting is not affected.
REQ-031 ack_err_o SHALL be cleared only by rst_i.

Verification
REQ-032 LAYERS=8, all enabled, each layer model busy 20 cycles, 2 cycles after its start pulse, gap_cnt_i=100 -> start pulses on layers 0..7 in order, then frame_done_o one pulse, then busy_o=0.
REQ-033 layer_en_i=8'b1010_0101 -> start pulses only on layers 0, 2, 5, 7, then one frame_done_o.
REQ-034 Layer 3 never raises busy -> ack_err_o=1 after ACK_TMO=15 cycles in ACK, then layer 4 is started, and the frame completes.
REQ-035 start_i pulsed 3 times mid-frame -> exactly one extra frame is run; 2 frame_done_o pulses in total; busy_o stays high between the frames.
REQ-036 gap_cnt_i=0 with all layers disabled -> frame_done_o appears 10 cycles after start_i (IDLE, 8 EVAL, GAP, then DONE asserted).
REQ-037 rst_i asserted during layer 4 RUN -> all outputs 0 the next cycle; a new start_i begins again at layer 0.
